// File: rtl/vm_change_dispenser.sv
// -----------------------------------------------------------------------------
// vm_change_dispenser
//
// Sequential change dispenser for the vending machine. A refund amount is
// accepted in IDLE and broken down greedily (largest coin first) into the
// coins actually held in inventory. Coins go out one at a time over a
// valid/ack handshake to the coin ejector. At the end of a request a one-cycle
// done pulse reports the amount paid and any unpayable residual.
// Per-denomination inventory counters are kept here, including refills.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous active-high reset
//   i_req_valid    refund request valid (held by requester until ready)
//   i_req_amount   refund amount, captured on valid && ready
//   o_req_ready    high only while idle
//   i_refill_coin  per-cycle bitmask, each set bit adds one coin of that index
//   o_eject_valid  eject request to the actuator
//   o_eject_coin   one-hot coin to eject, zero when not ejecting
//   i_eject_ack    actuator accepted the current coin
//   o_done         one-cycle pulse at the end of a request
//   o_residual     amount left unpaid (valid with o_done, held until next accept)
//   o_paid         amount actually ejected (same validity as o_residual)
//   o_coin_count   packed inventory, coin i at [i*CNT_BITS +: CNT_BITS]
// -----------------------------------------------------------------------------
module vm_change_dispenser #(
  parameter int NUM_COINS  = 3,
  parameter int TOTAL_BITS = 31,
  parameter int CNT_BITS   = 8,
  parameter int COIN_VAL0  = 100,
  parameter int COIN_VAL1  = 500,
  parameter int COIN_VAL2  = 1000,
  parameter int INIT_COUNT = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_req_valid,
  input  logic [TOTAL_BITS-1:0]         i_req_amount,
  output logic                          o_req_ready,
  input  logic [NUM_COINS-1:0]          i_refill_coin,
  output logic                          o_eject_valid,
  output logic [NUM_COINS-1:0]          o_eject_coin,
  input  logic                          i_eject_ack,
  output logic                          o_done,
  output logic [TOTAL_BITS-1:0]         o_residual,
  output logic [TOTAL_BITS-1:0]         o_paid,
  output logic [NUM_COINS*CNT_BITS-1:0] o_coin_count
);

  localparam int IDX_W = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_EJECT, S_DONE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [TOTAL_BITS-1:0] r_remaining;
  logic [TOTAL_BITS-1:0] r_paid;
  logic [IDX_W-1:0]      r_sel;
  logic [IDX_W-1:0]      w_pick;
  logic                  w_found;
  logic [CNT_BITS-1:0]   r_count [NUM_COINS];
  logic [TOTAL_BITS-1:0] w_sel_val;
  logic [TOTAL_BITS-1:0] w_rem_after;
  logic                  w_ack_take;

  // Denomination lookup. Unknown indices get an all-ones value so they can
  // never satisfy the "value <= remaining" test and stall the machine.
  function automatic logic [TOTAL_BITS-1:0] coin_val(input int idx);
    case (idx)
      0:       return TOTAL_BITS'(COIN_VAL0);
      1:       return TOTAL_BITS'(COIN_VAL1);
      2:       return TOTAL_BITS'(COIN_VAL2);
      default: return '1;
    endcase
  endfunction

  // Inventory update: saturating increment on refill, decrement on eject,
  // and a simultaneous refill + eject of the same coin cancel out.
  function automatic logic [CNT_BITS-1:0] cnt_update(input logic [CNT_BITS-1:0] cnt,
                                                     input logic inc,
                                                     input logic dec);
    if (inc && !dec)
      return (cnt == '1) ? cnt : cnt + CNT_BITS'(1);
    else if (dec && !inc)
      return cnt - CNT_BITS'(1);
    else
      return cnt;
  endfunction

  // Greedy pick: ascending scan, so the last hit is the highest eligible coin.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if ((r_count[i] != '0) && (coin_val(i) <= r_remaining)) begin
        w_found = 1'b1;
        w_pick  = IDX_W'(i);
      end
    end
  end

  assign w_sel_val   = coin_val(int'(r_sel));
  assign w_rem_after = r_remaining - w_sel_val;
  assign w_ack_take  = (r_state == S_EJECT) && i_eject_ack;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_req_valid) w_next = (i_req_amount == '0) ? S_DONE : S_SELECT;
      S_SELECT: w_next = w_found ? S_EJECT : S_DONE;
      S_EJECT:  if (i_eject_ack) w_next = (w_rem_after == '0) ? S_DONE : S_SELECT;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // FSM outputs; eject valid/coin derive from state and the latched pick,
  // so they stay stable for as long as the actuator withholds ack.
  always_comb begin
    o_req_ready   = (r_state == S_IDLE);
    o_eject_valid = (r_state == S_EJECT);
    o_done        = (r_state == S_DONE);
    o_eject_coin  = '0;
    if (r_state == S_EJECT) begin
      for (int i = 0; i < NUM_COINS; i++)
        o_eject_coin[i] = (r_sel == IDX_W'(i));
    end
  end

  // Remaining/paid bookkeeping. These double as the residual/paid outputs:
  // they only move on accept or on an acked coin, so they hold from the done
  // pulse until the next accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_remaining <= '0;
      r_paid      <= '0;
    end else if ((r_state == S_IDLE) && i_req_valid) begin
      r_remaining <= i_req_amount;
      r_paid      <= '0;
    end else if (w_ack_take) begin
      r_remaining <= w_rem_after;
      r_paid      <= r_paid + w_sel_val;
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == S_SELECT) && w_found) r_sel <= w_pick;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_COINS; i++) begin
      if (reset) r_count[i] <= CNT_BITS'(INIT_COUNT);
      else       r_count[i] <= cnt_update(r_count[i], i_refill_coin[i],
                                          w_ack_take && (r_sel == IDX_W'(i)));
    end
  end

  assign o_residual = r_remaining;
  assign o_paid     = r_paid;

  for (genvar g = 0; g < NUM_COINS; g++) begin : g_pack
    assign o_coin_count[g*CNT_BITS +: CNT_BITS] = r_count[g];
  end

endmodule

// File: tb/tb_vm_change_dispenser.sv
// -----------------------------------------------------------------------------
// tb_vm_change_dispenser
//
// Scoreboard bench for vm_change_dispenser. Expected coins and done results
// are queued when a request is issued; a negedge monitor pops and compares
// them as the DUT ejects coins and pulses done.
// -----------------------------------------------------------------------------
module tb_vm_change_dispenser;

  localparam int NC = 3;
  localparam int TB = 31;
  localparam int CB = 8;

  logic           clk;
  logic           reset;
  logic           i_req_valid;
  logic [TB-1:0]  i_req_amount;
  logic           o_req_ready;
  logic [NC-1:0]  i_refill_coin;
  logic           o_eject_valid;
  logic [NC-1:0]  o_eject_coin;
  logic           i_eject_ack;
  logic           o_done;
  logic [TB-1:0]  o_residual;
  logic [TB-1:0]  o_paid;
  logic [NC*CB-1:0] o_coin_count;

  vm_change_dispenser dut (
    .clk           (clk),
    .reset         (reset),
    .i_req_valid   (i_req_valid),
    .i_req_amount  (i_req_amount),
    .o_req_ready   (o_req_ready),
    .i_refill_coin (i_refill_coin),
    .o_eject_valid (o_eject_valid),
    .o_eject_coin  (o_eject_coin),
    .i_eject_ack   (i_eject_ack),
    .o_done        (o_done),
    .o_residual    (o_residual),
    .o_paid        (o_paid),
    .o_coin_count  (o_coin_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int cval [NC] = '{100, 500, 1000};
  int m_cnt [NC];
  int exp_coin_q [$];
  int exp_paid_q [$];
  int exp_res_q  [$];

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int cnt_of(input int i);
    return int'(o_coin_count[i*CB +: CB]);
  endfunction

  // Reference greedy decomposition against the bench's own inventory copy.
  task automatic model_req(input int amt);
    int  rem;
    int  paid;
    bit  found;
    rem  = amt;
    paid = 0;
    found = 1'b1;
    while (found && rem != 0) begin
      found = 1'b0;
      for (int i = NC - 1; i >= 0; i--) begin
        if (!found && m_cnt[i] > 0 && cval[i] <= rem) begin
          found = 1'b1;
          exp_coin_q.push_back(i);
          m_cnt[i]--;
          rem  -= cval[i];
          paid += cval[i];
        end
      end
    end
    exp_paid_q.push_back(paid);
    exp_res_q.push_back(rem);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < NC; i++) m_cnt[i] = 4;
  endtask

  task automatic send_req(input int amt, input bit use_model);
    bit acc;
    if (use_model) model_req(amt);
    i_req_valid  = 1'b1;
    i_req_amount = TB'(amt);
    acc = 1'b0;
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge clk);
      acc = o_req_ready;
      step();
    end
    i_req_valid = 1'b0;
    check("req_accepted", longint'(acc), 1);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 300 && !seen; t++) begin
      @(negedge clk);
      seen = o_done;
    end
    check("done_seen", longint'(seen), 1);
    step();
  endtask

  task automatic wait_eject();
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      seen = o_eject_valid;
    end
    check("eject_seen", longint'(seen), 1);
  endtask

  task automatic check_counts(input string tag);
    for (int i = 0; i < NC; i++) check(tag, longint'(cnt_of(i)), longint'(m_cnt[i]));
  endtask

  // Scoreboard monitor: inputs change just after posedge, so at negedge both
  // the DUT outputs and the handshake inputs for the coming edge are stable.
  always @(negedge clk) begin
    if (!reset) begin
      if (!o_eject_valid) check("coin_zero_when_idle", longint'(o_eject_coin), 0);
      if (o_eject_valid && i_eject_ack) begin
        check("eject_expected", longint'(exp_coin_q.size() != 0), 1);
        if (exp_coin_q.size() != 0) begin
          int c;
          c = exp_coin_q.pop_front();
          check("eject_coin", longint'(o_eject_coin), longint'(1) << c);
        end
      end
      if (o_done) begin
        check("done_expected", longint'(exp_paid_q.size() != 0), 1);
        if (exp_paid_q.size() != 0) begin
          int p;
          int r;
          p = exp_paid_q.pop_front();
          r = exp_res_q.pop_front();
          check("done_paid", longint'(o_paid), longint'(p));
          check("done_residual", longint'(o_residual), longint'(r));
        end
      end
    end
  end

  initial begin
    int lat;
    reset         = 1'b1;
    i_req_valid   = 1'b0;
    i_req_amount  = '0;
    i_refill_coin = '0;
    i_eject_ack   = 1'b0;
    for (int i = 0; i < NC; i++) m_cnt[i] = 4;
    repeat (3) step();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_ready", longint'(o_req_ready), 1);
    check("rst_eject_valid", longint'(o_eject_valid), 0);
    check("rst_eject_coin", longint'(o_eject_coin), 0);
    check("rst_done", longint'(o_done), 0);
    check("rst_residual", longint'(o_residual), 0);
    check("rst_paid", longint'(o_paid), 0);
    check_counts("rst_count");
    step();

    // 1600 with ack tied high: coin2, coin1, coin0; also first-eject latency
    i_eject_ack = 1'b1;
    send_req(1600, 1'b1);
    lat = 0;
    for (int t = 0; t < 20 && !o_eject_valid; t++) begin
      @(negedge clk);
      lat++;
    end
    check("first_eject_latency", longint'(lat), 2);
    wait_done();
    check_counts("cnt_after_1600");

    // Zero amount: done with nothing ejected
    send_req(0, 1'b1);
    wait_done();
    check_counts("cnt_after_0");

    // 5000 from fresh inventory, then 1000, then 250 (partial payment)
    do_reset();
    send_req(5000, 1'b1);
    wait_done();
    check_counts("cnt_after_5000");
    send_req(1000, 1'b1);
    wait_done();
    check_counts("cnt_after_1000");
    send_req(250, 1'b1);
    wait_done();
    check_counts("cnt_after_250");

    // Withheld ack: outputs stable, no count change; refill on ack cycle
    do_reset();
    i_eject_ack = 1'b0;
    exp_coin_q.push_back(1);
    exp_paid_q.push_back(500);
    exp_res_q.push_back(0);
    send_req(500, 1'b0);
    wait_eject();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_valid", longint'(o_eject_valid), 1);
      check("hold_coin", longint'(o_eject_coin), 2);
      check("hold_count1", longint'(cnt_of(1)), 4);
    end
    step();
    i_eject_ack   = 1'b1;
    i_refill_coin = 3'b010;
    step();
    i_eject_ack   = 1'b0;
    i_refill_coin = '0;
    wait_done();
    check_counts("cnt_refill_on_ack");

    // Spurious ack while idle
    i_eject_ack = 1'b1;
    repeat (4) step();
    i_eject_ack = 1'b0;
    @(negedge clk);
    check("idle_ack_valid", longint'(o_eject_valid), 0);
    check_counts("cnt_idle_ack");
    step();

    // Reset during the second eject of a 1600 request aborts it
    exp_coin_q.push_back(2);
    send_req(1600, 1'b0);
    wait_eject();
    step();
    i_eject_ack = 1'b1;
    step();
    i_eject_ack = 1'b0;
    wait_eject();
    check("abort_second_coin", longint'(o_eject_coin), 2);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < NC; i++) m_cnt[i] = 4;
    @(negedge clk);
    check("abort_eject_valid", longint'(o_eject_valid), 0);
    check("abort_ready", longint'(o_req_ready), 1);
    check("abort_done", longint'(o_done), 0);
    check_counts("cnt_after_abort");
    step();
    repeat (8) step();

    // Refill saturation on coin0
    i_refill_coin = 3'b001;
    repeat (300) step();
    i_refill_coin = '0;
    m_cnt[0] = 255;
    @(negedge clk);
    check_counts("cnt_saturate");
    step();

    check("coin_queue_drained", longint'(exp_coin_q.size()), 0);
    check("done_queue_drained", longint'(exp_paid_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
